// File: rtl/uart_frame_dispatch.sv
// uart_frame_dispatch
//   Parses framed bytes from a UART byte receiver and writes a channel word
//   register when a frame is well formed.
//   Frame layout: HDR_BYTE, channel index, DATA_BYTES payload bytes (MSB
//   first), then a checksum equal to the mod-256 sum of channel and payload.
//   A bad checksum, an out-of-range channel, or an inter-byte gap that is
//   too long all reject the frame and pulse frame_err.
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst    in   synchronous active-high reset
//   rx_data    in   received byte
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   ch_words   out  NUM_CH words of WORD_W bits, channel k at [k*WORD_W +: WORD_W]
//   ch_update  out  one-cycle pulse on the channel that was just written
//   frame_err  out  one-cycle pulse on a rejected or timed-out frame
//   err_cnt    out  saturating count of frame_err pulses
//   busy       out  high while a frame is in progress
module uart_frame_dispatch #(
    parameter int          NUM_CH      = 2,
    parameter int          WORD_W      = 16,
    parameter int          TIMEOUT_CYC = 156250,
    parameter logic [7:0]  HDR_BYTE    = 8'hAA
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [NUM_CH*WORD_W-1:0]   ch_words,
    output logic [NUM_CH-1:0]          ch_update,
    output logic                       frame_err,
    output logic [7:0]                 err_cnt,
    output logic                       busy
);

    localparam int DATA_BYTES = WORD_W / 8;
    localparam int CNT_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int BCNT_W     = $clog2(DATA_BYTES + 1);

    typedef enum logic [1:0] {IDLE, CHAN, DATA, CSUM} state_t;

    state_t                          state_q;
    logic [7:0]                      chan_q;
    logic [7:0]                      sum_q;
    logic [BCNT_W-1:0]               bcnt_q;
    logic [WORD_W-1:0]               shreg_q;
    logic [CNT_W-1:0]                tmo_q;
    logic [NUM_CH-1:0][WORD_W-1:0]   ch_words_q;
    logic [NUM_CH-1:0]               ch_update_q;
    logic                            frame_err_q;
    logic [7:0]                      err_cnt_q;

    logic tmo_hit;
    logic csum_byte;
    logic csum_ok;
    logic err_evt;

    always_comb begin
        // A byte arriving on the timeout cycle wins over the timeout.
        tmo_hit   = (state_q != IDLE) && !rx_valid && (tmo_q == CNT_W'(TIMEOUT_CYC - 1));
        csum_byte = rx_valid && (state_q == CSUM);
        csum_ok   = csum_byte && (rx_data == sum_q) && ({1'b0, chan_q} < 9'(NUM_CH));
        err_evt   = tmo_hit || (csum_byte && !csum_ok);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            chan_q      <= '0;
            sum_q       <= '0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            tmo_q       <= '0;
            ch_words_q  <= '0;
            ch_update_q <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            ch_update_q <= '0;
            frame_err_q <= err_evt;

            if (err_evt && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;

            // Gap counter: zero in IDLE, on any byte, and when a timeout fires.
            if (rx_valid || state_q == IDLE || tmo_hit)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + CNT_W'(1);

            if (tmo_hit) begin
                state_q <= IDLE;
            end else if (rx_valid) begin
                case (state_q)
                    IDLE: begin
                        if (rx_data == HDR_BYTE)
                            state_q <= CHAN;
                    end
                    CHAN: begin
                        chan_q  <= rx_data;
                        sum_q   <= rx_data;
                        bcnt_q  <= '0;
                        state_q <= DATA;
                    end
                    DATA: begin
                        shreg_q <= (shreg_q << 8) | WORD_W'(rx_data);
                        sum_q   <= sum_q + rx_data;
                        bcnt_q  <= bcnt_q + BCNT_W'(1);
                        if (bcnt_q == BCNT_W'(DATA_BYTES - 1))
                            state_q <= CSUM;
                    end
                    CSUM: begin
                        // csum_ok already guarantees chan_q < NUM_CH.
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (csum_ok && chan_q == 8'(k)) begin
                                ch_words_q[k]  <= shreg_q;
                                ch_update_q[k] <= 1'b1;
                            end
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ch_words  = ch_words_q;
    assign ch_update = ch_update_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != IDLE);

endmodule
